// File: rtl/en_tick_gen_pkg.sv
// Shared types and constants for the en_tick_gen enable-pulse generator.
package en_tick_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_CONT  = 1'b0;
    localparam logic MODE_BURST = 1'b1;

endpackage

// File: rtl/en_tick_gen_tick_prescaler.sv
// Prescale counter: counts 0..div_q and flags the terminal count so the FSM knows a pulse is due.
module tick_prescaler #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         advance,
    input  logic [W-1:0] div_q,
    output logic         tc
);

    logic [W-1:0] psc;

    assign tc = (psc == div_q);

    // Freezing is just "advance low": psc keeps its value so the remaining interval survives a pause.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            psc <= '0;
        end else if (clear) begin
            psc <= '0;
        end else if (advance) begin
            psc <= tc ? '0 : psc + 1'b1;
        end
    end

endmodule

// File: rtl/en_tick_gen.sv
// Programmable enable-pulse generator (continuous or burst) feeding nbit_counter.en.
// Optional pause input `hold` is compiled in when EN_TICK_GEN_PAUSE_EN is defined.
module en_tick_gen
    import en_tick_gen_pkg::*;
#(
    parameter int W = 8,
    parameter int B = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         stop,
    input  logic         mode,
    input  logic [W-1:0] div,
    input  logic [B-1:0] burst_len,
`ifdef EN_TICK_GEN_PAUSE_EN
    input  logic         hold,
`endif
    output logic         en,
    output logic         busy,
    output logic         done,
    output logic [B-1:0] pulse_cnt
);

`ifndef EN_TICK_GEN_PAUSE_EN
    logic hold;
    assign hold = 1'b0;
`endif

    state_t       state;
    state_t       next_state;
    logic [W-1:0] div_q;
    logic [B-1:0] burst_q;
    logic         mode_q;

    logic         accept;
    logic         advance;
    logic         clear;
    logic         tc;
    logic         pulse_due;
    logic [B-1:0] cnt_inc;

    logic         en_d;
    logic         busy_d;
    logic         done_d;
    logic [B-1:0] cnt_d;

    assign accept    = (state == IDLE) && start && !stop;
    assign advance   = (state == RUN) && !stop && !hold;
    assign clear     = accept || ((state == RUN) && stop);
    assign pulse_due = advance && tc;
    assign cnt_inc   = pulse_cnt + 1'b1;

    tick_prescaler #(
        .W(W)
    ) u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (clear),
        .advance(advance),
        .div_q  (div_q),
        .tc     (tc)
    );

    // State register; outputs are registered alongside it so busy/en/done never glitch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            en        <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pulse_cnt <= '0;
            div_q     <= '0;
            burst_q   <= '0;
            mode_q    <= MODE_CONT;
        end else begin
            state     <= next_state;
            en        <= en_d;
            busy      <= busy_d;
            done      <= done_d;
            pulse_cnt <= cnt_d;
            if (accept) begin
                div_q   <= div;
                burst_q <= burst_len;
                mode_q  <= mode;
            end
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    next_state = ((mode == MODE_BURST) && (burst_len == '0)) ? DONE : RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    next_state = IDLE;
                end else if (pulse_due && (mode_q == MODE_BURST) && (cnt_inc == burst_q)) begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // done trails the DONE state by one cycle, so the final en and the done pulse never overlap.
    always_comb begin
        en_d   = pulse_due;
        busy_d = (next_state == RUN);
        done_d = (state == DONE);
        cnt_d  = pulse_cnt;
        if (accept) begin
            cnt_d = '0;
        end else if (pulse_due) begin
            cnt_d = cnt_inc;
        end
    end

endmodule

// File: tb/tb_en_tick_gen.sv
// Directed scoreboard bench for en_tick_gen; the pause scenario runs when EN_TICK_GEN_PAUSE_EN is defined.
module tb_en_tick_gen;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic       mode;
    logic [7:0] div;
    logic [7:0] burst_len;
    logic       hold;
    logic       en;
    logic       busy;
    logic       done;
    logic [7:0] pulse_cnt;

    int checks = 0;
    int errors = 0;

    logic [10:0] exp_q[$];
    string       tag_q[$];

    en_tick_gen #(
        .W(8),
        .B(8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stop     (stop),
        .mode     (mode),
        .div      (div),
        .burst_len(burst_len),
`ifdef EN_TICK_GEN_PAUSE_EN
        .hold     (hold),
`endif
        .en       (en),
        .busy     (busy),
        .done     (done),
        .pulse_cnt(pulse_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output();
        logic [10:0] obs;
        logic [10:0] exp;
        string       tag;
        obs = {en, busy, done, pulse_cnt};
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_empty: observed %b, required an expectation", obs);
        end else begin
            exp = exp_q.pop_front();
            tag = tag_q.pop_front();
            assert (obs === exp)
            else begin
                errors++;
                $error("[TB] FAIL %s: observed en=%b busy=%b done=%b cnt=%0d, expected en=%b busy=%b done=%b cnt=%0d",
                       tag, obs[10], obs[9], obs[8], obs[7:0], exp[10], exp[9], exp[8], exp[7:0]);
            end
        end
    endtask

    // Push the expectation for the coming edge, clock it, then compare 1 time unit later.
    task automatic apply_stimulus(input string tag, input logic e, input logic b,
                                  input logic d, input logic [7:0] c);
        exp_q.push_back({e, b, d, c});
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        check_output();
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        mode      = 1'b0;
        div       = 8'd0;
        burst_len = 8'd0;
        hold      = 1'b0;
        @(negedge clk);

        apply_stimulus("reset", 1'b0, 1'b0, 1'b0, 8'd0);
        apply_stimulus("reset_hold", 1'b0, 1'b0, 1'b0, 8'd0);
        rst_n = 1'b1;

        // Continuous, div=3: en every 4th cycle, first one 4 edges after start.
        mode  = 1'b0;
        div   = 8'd3;
        start = 1'b1;
        apply_stimulus("cont_start", 1'b0, 1'b1, 1'b0, 8'd0);
        start = 1'b0;
        for (int j = 1; j <= 12; j++)
            apply_stimulus("cont_run", (j % 4) == 0, 1'b1, 1'b0, 8'(j / 4));
        stop = 1'b1;
        apply_stimulus("cont_stop", 1'b0, 1'b0, 1'b0, 8'd3);
        stop = 1'b0;
        apply_stimulus("cont_idle", 1'b0, 1'b0, 1'b0, 8'd3);

        // Burst of 5, div=2; inputs scrambled after start must not matter.
        mode      = 1'b1;
        div       = 8'd2;
        burst_len = 8'd5;
        start     = 1'b1;
        apply_stimulus("burst_start", 1'b0, 1'b1, 1'b0, 8'd0);
        start     = 1'b0;
        mode      = 1'b0;
        div       = 8'd9;
        burst_len = 8'd1;
        for (int j = 1; j <= 14; j++)
            apply_stimulus("burst_run", (j % 3) == 0, 1'b1, 1'b0, 8'(j / 3));
        apply_stimulus("burst_last", 1'b1, 1'b0, 1'b0, 8'd5);
        start = 1'b1;
        apply_stimulus("burst_done", 1'b0, 1'b0, 1'b1, 8'd5);
        start = 1'b0;
        apply_stimulus("burst_idle", 1'b0, 1'b0, 1'b0, 8'd5);

        // div=0: en solid high, stop overrides the pulse due at the same edge.
        mode  = 1'b0;
        div   = 8'd0;
        start = 1'b1;
        apply_stimulus("div0_start", 1'b0, 1'b1, 1'b0, 8'd0);
        start = 1'b0;
        for (int j = 1; j <= 10; j++)
            apply_stimulus("div0_run", 1'b1, 1'b1, 1'b0, 8'(j));
        stop = 1'b1;
        apply_stimulus("div0_stop", 1'b0, 1'b0, 1'b0, 8'd10);
        stop = 1'b0;
        apply_stimulus("div0_idle", 1'b0, 1'b0, 1'b0, 8'd10);

        // Zero-length burst: straight to DONE, busy never rises.
        mode      = 1'b1;
        div       = 8'd2;
        burst_len = 8'd0;
        start     = 1'b1;
        apply_stimulus("zero_start", 1'b0, 1'b0, 1'b0, 8'd0);
        start = 1'b0;
        apply_stimulus("zero_done", 1'b0, 1'b0, 1'b1, 8'd0);
        apply_stimulus("zero_idle", 1'b0, 1'b0, 1'b0, 8'd0);

        // start with stop together is refused; then div change mid-run is ignored.
        mode  = 1'b0;
        div   = 8'd1;
        start = 1'b1;
        stop  = 1'b1;
        apply_stimulus("startstop", 1'b0, 1'b0, 1'b0, 8'd0);
        start = 1'b0;
        stop  = 1'b0;
        apply_stimulus("startstop_idle", 1'b0, 1'b0, 1'b0, 8'd0);
        start = 1'b1;
        apply_stimulus("div1_start", 1'b0, 1'b1, 1'b0, 8'd0);
        start = 1'b0;
        div   = 8'd7;
        for (int j = 1; j <= 8; j++)
            apply_stimulus("div1_run", (j % 2) == 0, 1'b1, 1'b0, 8'(j / 2));
        stop = 1'b1;
        apply_stimulus("div1_stop", 1'b0, 1'b0, 1'b0, 8'd4);
        stop = 1'b0;

        // Reset in the middle of a burst, then a fresh start counts from zero.
        mode      = 1'b1;
        div       = 8'd1;
        burst_len = 8'd8;
        start     = 1'b1;
        apply_stimulus("rst_start", 1'b0, 1'b1, 1'b0, 8'd0);
        start = 1'b0;
        for (int j = 1; j <= 6; j++)
            apply_stimulus("rst_run", (j % 2) == 0, 1'b1, 1'b0, 8'(j / 2));
        rst_n = 1'b0;
        apply_stimulus("rst_mid", 1'b0, 1'b0, 1'b0, 8'd0);
        rst_n = 1'b1;
        mode  = 1'b0;
        start = 1'b1;
        apply_stimulus("rst_restart", 1'b0, 1'b1, 1'b0, 8'd0);
        start = 1'b0;
        for (int j = 1; j <= 4; j++)
            apply_stimulus("rst_fresh", (j % 2) == 0, 1'b1, 1'b0, 8'(j / 2));
        stop = 1'b1;
        apply_stimulus("rst_stop", 1'b0, 1'b0, 1'b0, 8'd2);
        stop = 1'b0;

`ifdef EN_TICK_GEN_PAUSE_EN
        // Six held cycles mid-interval push every later pulse back by exactly six.
        mode  = 1'b0;
        div   = 8'd4;
        start = 1'b1;
        apply_stimulus("pause_start", 1'b0, 1'b1, 1'b0, 8'd0);
        start = 1'b0;
        for (int j = 1; j <= 2; j++)
            apply_stimulus("pause_pre", 1'b0, 1'b1, 1'b0, 8'd0);
        hold = 1'b1;
        for (int j = 3; j <= 8; j++)
            apply_stimulus("pause_hold", 1'b0, 1'b1, 1'b0, 8'd0);
        hold = 1'b0;
        for (int j = 9; j <= 17; j++)
            apply_stimulus("pause_resume", ((j - 6) % 5) == 0, 1'b1, 1'b0, 8'((j - 6) / 5));
        hold = 1'b1;
        stop = 1'b1;
        apply_stimulus("pause_stop", 1'b0, 1'b0, 1'b0, 8'd2);
        hold = 1'b0;
        stop = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
